// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the four-channel mux scan sequencer.
// Channel index to select-line mapping lives here so every user agrees on it.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    // Returns {sel0, sel1}: sel0 is the index MSB, sel1 the LSB.
    function automatic logic [1:0] ch_to_sel(input logic [CH_W-1:0] ch);
        return {ch[1], ch[0]};
    endfunction

endpackage

// File: rtl/scan_next_channel.sv
// Combinational search for the next enabled channel above the current one,
// or for the lowest enabled channel when a scan is just starting.
module scan_next_channel
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              from_start,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);

    // Descending walk so the lowest qualifying index wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || i > int'(cur))) begin
                nxt   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan controller for a 4:1 mux: steps enabled channels, waits the settle
// time, samples mux_out per channel and returns a 4-bit result word.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ch_mask,
    input  logic       mux_out,
    output logic       sel0,
    output logic       sel1,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data
);

    localparam logic [3:0] LOAD = 4'(SETTLE_CYCLES);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [3:0]        data_d;
    logic [1:0]        sel_d;

    logic [NUM_CH-1:0] nc_mask;
    logic              nc_from_start;
    logic [CH_W-1:0]   nc_nxt;
    logic              nc_found;

    // In IDLE the search runs on the live mask so the first channel
    // is known at the accepting edge.
    assign nc_from_start = (state_q == IDLE);
    assign nc_mask       = nc_from_start ? ch_mask : mask_q;

    scan_next_channel u_next (
        .mask       (nc_mask),
        .cur        (ch_q),
        .from_start (nc_from_start),
        .nxt        (nc_nxt),
        .found      (nc_found)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        data_d  = out_data;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    data_d = '0;
                    if (nc_found) begin
                        ch_d    = nc_nxt;
                        cnt_d   = LOAD;
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d[ch_q] = mux_out;
                    if (nc_found) begin
                        ch_d  = nc_nxt;
                        cnt_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d = (state_d == SETTLE) ? ch_to_sel(ch_d) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            out_data  <= '0;
            sel0      <= 1'b0;
            sel1      <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            out_data  <= data_d;
            sel0      <= sel_d[1];
            sel1      <= sel_d[0];
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed scoreboard bench for mux_scan_sequencer, three settle settings
// side by side, each driving its own behavioural 4:1 mux model.
module tb_mux_scan_sequencer;

    localparam int ND = 3;
    localparam int SC [ND] = '{1, 0, 3};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    ch_mask = '0;
    logic [3:0]    ivals = '0;
    logic [ND-1:0] start = '0;
    logic [ND-1:0] mux_out, sel0, sel1, busy, out_valid;
    logic [3:0]    out_data [ND];

    logic [3:0] sb [$];
    int nasrt = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        assign mux_out[g] = ivals[{sel0[g], sel1[g]}];
        mux_scan_sequencer #(.SETTLE_CYCLES(SC[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .ch_mask   (ch_mask),
            .mux_out   (mux_out[g]),
            .sel0      (sel0[g]),
            .sel1      (sel1[g]),
            .busy      (busy[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_data  (out_data[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input int d, input logic [3:0] m, input bit bp);
        int chl [4];
        int n;
        int s;
        int cyc;
        int idx;
        logic [3:0] exp;
        n = 0;
        s = SC[d];
        for (int i = 0; i < 4; i++) begin
            chl[i] = 0;
            if (m[i]) begin
                chl[n] = i;
                n++;
            end
        end
        @(negedge clk);
        ch_mask  = m;
        start[d] = 1'b1;
        out_ready = !bp;
        sb.push_back(m & ivals);
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        ch_mask  = ~m;
        cyc = 1;
        chk("busy_c1", 32'(busy[d]), 1);
        while (!out_valid[d] && cyc < 200) begin
            idx = (cyc - 1) / (s + 1);
            chk("sel", 32'({sel0[d], sel1[d]}), (idx < n) ? chl[idx] : 99);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, 1 + n * (s + 1));
        chk("sel_done", 32'({sel0[d], sel1[d]}), 0);
        exp = sb.pop_front();
        chk("data", 32'(out_data[d]), 32'(exp));
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                start[d] = (k == 1);
                ch_mask  = 4'hf;
                @(posedge clk);
                #1;
                chk("bp_valid", 32'(out_valid[d]), 1);
                chk("bp_data", 32'(out_data[d]), 32'(exp));
            end
            @(negedge clk);
            start[d]  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("idle_valid", 32'(out_valid[d]), 0);
        chk("idle_busy", 32'(busy[d]), 0);
    endtask

    initial begin
        ivals = 4'b0110;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_valid", 32'(out_valid[d]), 0);
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_sel", 32'({sel0[d], sel1[d]}), 0);
            chk("rst_data", 32'(out_data[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        ivals = 4'b1001;
        scan(0, 4'b1111, 1'b0);
        ivals = 4'b1111;
        scan(0, 4'b0101, 1'b0);
        scan(0, 4'b0000, 1'b0);
        ivals = 4'b0110;
        scan(0, 4'b1110, 1'b1);
        scan(0, 4'b1011, 1'b0);

        // Reset while the second channel is being settled.
        ivals = 4'b1001;
        @(negedge clk);
        ch_mask  = 4'hf;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_sel", 32'({sel0[0], sel1[0]}), 1);
        chk("pre_rst_data", 32'(out_data[0]), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy[0]), 0);
        chk("mid_rst_sel", 32'({sel0[0], sel1[0]}), 0);
        chk("mid_rst_valid", 32'(out_valid[0]), 0);
        chk("mid_rst_data", 32'(out_data[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        scan(0, 4'b1111, 1'b0);

        ivals = 4'b1001;
        scan(1, 4'b1111, 1'b0);
        scan(2, 4'b1111, 1'b0);
        ivals = 4'b0100;
        scan(2, 4'b0110, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasrt, nfail);
        $finish;
    end

endmodule
